hazard_controller: RTL and testbench
====================================

// Module: hazard_controller
// PURPOSE
//  Pipeline sequencing controller for the 5-stage core. Watches ID source regs, EX/M/W destinations,
//  EX branch redirects and the data-memory handshake. Drives stall/flush for the IF/ID and ID/EX
//  registers and forwarding selects for the EX operand muxes. Holds the memory-wait FSM, a
//  deferred-redirect latch, a timeout watchdog and a stall-cycle counter.
// PARAMETERS
//  MEM_TIMEOUT  255  max cycles in MEM_WAIT before abort; must fit in TO_W bits
//  TO_W         8    width of the wait counter
//  CNT_W        32   width of perf_stall_cnt
// PORTS
//  clk            in   1      core clock, all state on posedge
//  rst            in   1      asynchronous, active-high reset
//  en             in   1      global enable; when 0, FSM and counters hold and combinational outputs still evaluate
//  ID_rs1/ID_rs2  in   5      source regs of instruction in ID (0 = unused)
//  EX_rd          in   5      destination reg in EX
//  EX_RegWrite    in   1      write-enable for EX_rd
//  EX_MemRead     in   1      the instruction in EX is a load
//  M_rd           in   5      destination reg in MEM
//  M_RegWrite     in   1      write-enable for M_rd
//  W_rd           in   5      destination reg in WB
//  W_RegWrite     in   1      write-enable for W_rd
//  EX_redirect    in   1      branch/jump taken in EX this cycle
//  mem_req        in   1      MEM stage issues a data access
//  mem_ready      in   1      data memory completes the access this cycle
//  stall          out  1      hold PC and IF/ID
//  flush_id       out  1      clear IF/ID
//  flush_ex       out  1      insert a bubble into ID/EX
//  fwdA/fwdB      out  2      EX operand select: 0 = regfile, 1 = MEM result, 2 = WB result
//  mem_busy       out  1      FSM is in MEM_WAIT
//  timeout_err    out  1      sticky; set on a memory timeout
//  perf_stall_cnt out  CNT_W  count of cycles with stall=1; saturates
// BEHAVIOUR
//  Reset: state=RUN, wait_cnt=0, redir_pend=0, timeout_err=0, perf_stall_cnt=0. All outputs 0 in RUN with idle inputs.
//  FSM states:
//   RUN -> MEM_WAIT when mem_req & !mem_ready.
//   MEM_WAIT -> RUN when mem_ready, or when wait_cnt==MEM_TIMEOUT-1 (sets timeout_err).
//   wait_cnt clears on entry to MEM_WAIT and increments each cycle in MEM_WAIT.
//  MEM_WAIT: stall=1 and flush_ex=0, because the whole pipe freezes (EX/MEM also hold via mem_busy).
//   EX_redirect seen in MEM_WAIT sets redir_pend.
//  RUN with redir_pend=1: flush_id=flush_ex=1 for exactly one cycle, then redir_pend clears.
//  Outputs in RUN, combinational, in priority order:
//   1) EX_redirect | redir_pend: flush_id=1, flush_ex=1, stall=0.
//   2) mem_req & !mem_ready: stall=1 in this same cycle. The FSM enters MEM_WAIT next edge.
//   3) Load-use, i.e. EX_MemRead & EX_rd!=0 & (EX_rd==ID_rs1 | EX_rd==ID_rs2): stall=1, flush_ex=1 for one cycle.
//   4) Otherwise no stall.
//  Redirect and load-use in the same cycle: the redirect wins and no stall is raised.
//  fwdA (fwdB uses rs2 the same way): 1 if M_RegWrite & M_rd!=0 & M_rd==rs1; else 2 if W_RegWrite & W_rd!=0 & W_rd==rs1; else 0. MEM beats WB.
//  Register x0 never forwards and never causes a stall.
//  perf_stall_cnt +1 each en cycle with stall=1. It holds at all-ones.
//  Reset asserted mid-MEM_WAIT: immediate return to RUN, and any pending redirect is dropped.
// CONFIGURATION
//  FORWARDING_EN defined: behaviour as above.
//  FORWARDING_EN undefined: fwdA=fwdB=0 always. Rule 3 is widened to any RAW hazard, meaning a
//   nonzero rs matching EX_rd, M_rd or W_rd with its RegWrite set. That gives stall=1, flush_ex=1
//   each cycle until the producer retires (up to 3 cycles).
// TESTING
//  T1 reset: pulse rst mid-run -> every output 0, perf_stall_cnt=0, timeout_err=0.
//  T2 load-use: EX lw x5 (EX_MemRead=1, EX_rd=5); ID_rs1=5 -> stall=1, flush_ex=1 for 1 cycle,
//     then fwdA=1 next cycle.
//  T3 forwarding priority: M_rd=W_rd=7, both RegWrite; ID_rs2=7 -> fwdB=1. Set M_RegWrite=0 -> fwdB=2.
//     ID_rs1=0 with M_rd=0 -> fwdA=0.
//  T4 memory wait plus redirect: mem_req=1, mem_ready=0 for 4 cycles, EX_redirect pulsed in cycle 2
//     -> stall=1 and mem_busy=1 during the wait, then one cycle of flush_id=flush_ex=1 after mem_ready.
//  T5 timeout: MEM_TIMEOUT=4, mem_ready held 0 -> back in RUN after 4 wait cycles, and timeout_err=1
//     stays set until rst.
//  T6 without FORWARDING_EN: M_rd=3 with RegWrite, ID_rs1=3 -> stall for 2 cycles until retire,
//     fwdA=0 throughout.

Source files
------------

// File: rtl/hazard_controller.sv
// hazard_controller: stall/flush/forwarding sequencer for the 5-stage core.
// Contains the memory-wait FSM, a deferred-redirect latch, a wait watchdog
// and a saturating stall-cycle counter.
// Build option: define FORWARDING_EN to enable EX operand forwarding. Without
// it, forwarding selects stay 0 and every RAW hazard stalls until retire.
module hazard_controller #(
    parameter int MEM_TIMEOUT = 255,
    parameter int TO_W        = 8,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [4:0]       ID_rs1,
    input  logic [4:0]       ID_rs2,
    input  logic [4:0]       EX_rd,
    input  logic             EX_RegWrite,
    input  logic             EX_MemRead,
    input  logic [4:0]       M_rd,
    input  logic             M_RegWrite,
    input  logic [4:0]       W_rd,
    input  logic             W_RegWrite,
    input  logic             EX_redirect,
    input  logic             mem_req,
    input  logic             mem_ready,
    output logic             stall,
    output logic             flush_id,
    output logic             flush_ex,
    output logic [1:0]       fwdA,
    output logic [1:0]       fwdB,
    output logic             mem_busy,
    output logic             timeout_err,
    output logic [CNT_W-1:0] perf_stall_cnt
);

    typedef enum logic {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } state_t;

    // Last wait_cnt value before the watchdog aborts the access.
    localparam logic [TO_W-1:0] TIMEOUT_LAST = TO_W'(MEM_TIMEOUT - 1);

    state_t           state_q;
    logic [TO_W-1:0]  wait_cnt_q;
    logic             redir_pend_q;
    logic             timeout_err_q;
    logic [CNT_W-1:0] perf_cnt_q;
    logic [CNT_W-1:0] perf_cnt_d;

    logic             hazard;
    logic             mem_miss;

    assign mem_miss = mem_req && !mem_ready;

`ifdef FORWARDING_EN
    // Only a load in EX needs a bubble; everything else is forwarded.
    logic unused_ex_regwrite;
    assign unused_ex_regwrite = EX_RegWrite;

    // Operand select: MEM result is newer than WB, so it wins.
    always_comb begin
        fwdA = 2'd0;
        fwdB = 2'd0;
        if (M_RegWrite && (M_rd != 5'd0) && (M_rd == ID_rs1))
            fwdA = 2'd1;
        else if (W_RegWrite && (W_rd != 5'd0) && (W_rd == ID_rs1))
            fwdA = 2'd2;
        if (M_RegWrite && (M_rd != 5'd0) && (M_rd == ID_rs2))
            fwdB = 2'd1;
        else if (W_RegWrite && (W_rd != 5'd0) && (W_rd == ID_rs2))
            fwdB = 2'd2;
    end

    assign hazard = EX_MemRead && (EX_rd != 5'd0) &&
                    ((EX_rd == ID_rs1) || (EX_rd == ID_rs2));
`else
    logic [1:0] raw_hit;

    assign fwdA = 2'd0;
    assign fwdB = 2'd0;

    // Any in-flight producer of a nonzero source register blocks ID.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_raw
            logic [4:0] rs;
            assign rs = (gi == 0) ? ID_rs1 : ID_rs2;
            assign raw_hit[gi] = (rs != 5'd0) &&
                (((EX_RegWrite || EX_MemRead) && (EX_rd == rs)) ||
                 (M_RegWrite && (M_rd == rs)) ||
                 (W_RegWrite && (W_rd == rs)));
        end
    endgenerate

    assign hazard = |raw_hit;
`endif

    // Pipeline control outputs; in MEM_WAIT the whole pipe freezes without bubbles.
    always_comb begin
        stall    = 1'b0;
        flush_id = 1'b0;
        flush_ex = 1'b0;
        if (state_q == MEM_WAIT) begin
            stall = 1'b1;
        end else if (EX_redirect || redir_pend_q) begin
            flush_id = 1'b1;
            flush_ex = 1'b1;
        end else if (mem_miss) begin
            stall = 1'b1;
        end else if (hazard) begin
            stall    = 1'b1;
            flush_ex = 1'b1;
        end
    end

    // Memory-wait FSM with watchdog and deferred redirect latch.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= RUN;
            wait_cnt_q    <= '0;
            redir_pend_q  <= 1'b0;
            timeout_err_q <= 1'b0;
        end else if (en) begin
            case (state_q)
                RUN: begin
                    // The pending flush is emitted this cycle, so retire it.
                    redir_pend_q <= 1'b0;
                    if (mem_miss) begin
                        state_q    <= MEM_WAIT;
                        wait_cnt_q <= '0;
                    end
                end
                MEM_WAIT: begin
                    if (EX_redirect)
                        redir_pend_q <= 1'b1;
                    if (mem_ready) begin
                        state_q <= RUN;
                    end else if (wait_cnt_q == TIMEOUT_LAST) begin
                        state_q       <= RUN;
                        timeout_err_q <= 1'b1;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + 1'b1;
                    end
                end
                default: state_q <= RUN;
            endcase
        end
    end

    // Stall-cycle counter that sticks at all-ones.
    always_comb begin
        perf_cnt_d = perf_cnt_q;
        if (en && stall && (perf_cnt_q != {CNT_W{1'b1}}))
            perf_cnt_d = perf_cnt_q + 1'b1;
    end

    // Counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            perf_cnt_q <= '0;
        else
            perf_cnt_q <= perf_cnt_d;
    end

    assign mem_busy       = (state_q == MEM_WAIT);
    assign timeout_err    = timeout_err_q;
    assign perf_stall_cnt = perf_cnt_q;

endmodule

// File: tb/tb_hazard_controller.sv
// Scoreboard bench for hazard_controller (MEM_TIMEOUT=4, 4-bit stall counter).
// Expectations adapt to whether FORWARDING_EN is defined for the build.
module tb_hazard_controller;

`ifdef FORWARDING_EN
    localparam bit F = 1'b1;
`else
    localparam bit F = 1'b0;
`endif
    localparam int CNT_W = 4;
    localparam int PERF_MAX = 15;

    logic clk, rst, en;
    logic [4:0] ID_rs1, ID_rs2, EX_rd, M_rd, W_rd;
    logic EX_RegWrite, EX_MemRead, M_RegWrite, W_RegWrite;
    logic EX_redirect, mem_req, mem_ready;
    logic stall, flush_id, flush_ex, mem_busy, timeout_err;
    logic [1:0] fwdA, fwdB;
    logic [CNT_W-1:0] perf_stall_cnt;

    hazard_controller #(.MEM_TIMEOUT(4), .TO_W(8), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .en(en),
        .ID_rs1(ID_rs1), .ID_rs2(ID_rs2),
        .EX_rd(EX_rd), .EX_RegWrite(EX_RegWrite), .EX_MemRead(EX_MemRead),
        .M_rd(M_rd), .M_RegWrite(M_RegWrite),
        .W_rd(W_rd), .W_RegWrite(W_RegWrite),
        .EX_redirect(EX_redirect), .mem_req(mem_req), .mem_ready(mem_ready),
        .stall(stall), .flush_id(flush_id), .flush_ex(flush_ex),
        .fwdA(fwdA), .fwdB(fwdB), .mem_busy(mem_busy),
        .timeout_err(timeout_err), .perf_stall_cnt(perf_stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic [8:0] outs;   // {stall, flush_id, flush_ex, fwdA, fwdB, mem_busy, timeout_err}
        int         perf;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;
    int   exp_perf = 0;

    // Monitor: every cycle with an expected entry is compared mid-cycle.
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            logic [8:0] act;
            e = sb.pop_front();
            act = {stall, flush_id, flush_ex, fwdA, fwdB, mem_busy, timeout_err};
            checks++;
            if (act !== e.outs || int'(perf_stall_cnt) != e.perf) begin
                errors++;
                $display("FAIL %s: got outs=%b perf=%0d, expected outs=%b perf=%0d",
                         e.name, act, perf_stall_cnt, e.outs, e.perf);
            end else begin
                $display("ok   %s: outs=%b perf=%0d", e.name, act, perf_stall_cnt);
            end
        end
    end

    task automatic idle();
        en = 1'b1; rst = 1'b0;
        ID_rs1 = 0; ID_rs2 = 0; EX_rd = 0; M_rd = 0; W_rd = 0;
        EX_RegWrite = 0; EX_MemRead = 0; M_RegWrite = 0; W_RegWrite = 0;
        EX_redirect = 0; mem_req = 0; mem_ready = 0;
    endtask

    // Push expectation for the inputs currently applied, then advance one cycle.
    task automatic step(input string name, input logic s, input logic fi, input logic fe,
                        input logic [1:0] fa, input logic [1:0] fb,
                        input logic busy, input logic to);
        exp_t e;
        if (rst) exp_perf = 0;
        e.name = name;
        e.outs = {s, fi, fe, fa, fb, busy, to};
        e.perf = exp_perf;
        sb.push_back(e);
        @(posedge clk); #1;
        if (!rst && en && s && exp_perf < PERF_MAX) exp_perf++;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        idle();
        rst = 1'b1;
        @(posedge clk); #1;

        // Reset and idle
        step("reset", 0, 0, 0, 2'd0, 2'd0, 0, 0);
        idle();
        step("idle", 0, 0, 0, 2'd0, 2'd0, 0, 0);

        // Load-use, then producer moves to MEM and WB
        idle(); EX_MemRead = 1; EX_RegWrite = 1; EX_rd = 5; ID_rs1 = 5;
        step("load_use", 1, 0, 1, 2'd0, 2'd0, 0, 0);
        idle(); M_rd = 5; M_RegWrite = 1; ID_rs1 = 5;
        step("lu_in_mem", !F, 0, !F, F ? 2'd1 : 2'd0, 2'd0, 0, 0);
        idle(); W_rd = 5; W_RegWrite = 1; ID_rs1 = 5;
        step("lu_in_wb", !F, 0, !F, F ? 2'd2 : 2'd0, 2'd0, 0, 0);
        idle(); ID_rs1 = 5;
        step("lu_retired", 0, 0, 0, 2'd0, 2'd0, 0, 0);

        // Forwarding priority on rs2
        idle(); M_rd = 7; W_rd = 7; M_RegWrite = 1; W_RegWrite = 1; ID_rs2 = 7;
        step("fwdB_mem_wins", !F, 0, !F, 2'd0, F ? 2'd1 : 2'd0, 0, 0);
        idle(); M_rd = 7; W_rd = 7; W_RegWrite = 1; ID_rs2 = 7;
        step("fwdB_wb", !F, 0, !F, 2'd0, F ? 2'd2 : 2'd0, 0, 0);
        idle(); M_rd = 6; W_rd = 6; M_RegWrite = 1; W_RegWrite = 1; ID_rs1 = 6;
        step("fwdA_mem_wins", !F, 0, !F, F ? 2'd1 : 2'd0, 2'd0, 0, 0);
        idle(); M_rd = 9; W_rd = 4; M_RegWrite = 1; W_RegWrite = 1; ID_rs1 = 4; ID_rs2 = 9;
        step("fwd_split", !F, 0, !F, F ? 2'd2 : 2'd0, F ? 2'd1 : 2'd0, 0, 0);

        // Register x0 never forwards or stalls
        idle(); M_RegWrite = 1; W_RegWrite = 1;
        step("x0_no_fwd", 0, 0, 0, 2'd0, 2'd0, 0, 0);
        idle(); EX_MemRead = 1; EX_RegWrite = 1;
        step("x0_no_stall", 0, 0, 0, 2'd0, 2'd0, 0, 0);

        // Redirect beats load-use
        idle(); EX_redirect = 1; EX_MemRead = 1; EX_RegWrite = 1; EX_rd = 5; ID_rs1 = 5;
        step("redir_over_lu", 0, 1, 1, 2'd0, 2'd0, 0, 0);

        // Repeated load-use drives the counter into saturation
        for (int i = 0; i < 6; i++) begin
            idle(); EX_MemRead = 1; EX_RegWrite = 1; EX_rd = 8; ID_rs2 = 8;
            step($sformatf("lu_rs2_%0d", i), 1, 0, 1, 2'd0, 2'd0, 0, 0);
        end

        // Memory wait with redirect arriving during the wait
        idle(); mem_req = 1;
        step("mw_enter", 1, 0, 0, 2'd0, 2'd0, 0, 0);
        idle(); mem_req = 1; EX_redirect = 1;
        step("mw_redir", 1, 0, 0, 2'd0, 2'd0, 1, 0);
        idle(); mem_req = 1;
        step("mw_wait", 1, 0, 0, 2'd0, 2'd0, 1, 0);
        idle(); mem_req = 1; mem_ready = 1;
        step("mw_done", 1, 0, 0, 2'd0, 2'd0, 1, 0);
        idle();
        step("mw_pend_flush", 0, 1, 1, 2'd0, 2'd0, 0, 0);
        idle();
        step("mw_after", 0, 0, 0, 2'd0, 2'd0, 0, 0);

        // Timeout after 4 wait cycles
        idle(); mem_req = 1;
        step("to_enter", 1, 0, 0, 2'd0, 2'd0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            idle();
            step($sformatf("to_wait_%0d", i), 1, 0, 0, 2'd0, 2'd0, 1, 0);
        end
        idle();
        step("to_set", 0, 0, 0, 2'd0, 2'd0, 0, 1);
        idle();
        step("to_sticky", 0, 0, 0, 2'd0, 2'd0, 0, 1);

        // Enable low: outputs evaluate but FSM holds
        idle(); en = 0; mem_req = 1;
        step("en_hold", 1, 0, 0, 2'd0, 2'd0, 0, 1);
        idle();
        step("en_no_entry", 0, 0, 0, 2'd0, 2'd0, 0, 1);

        // Reset in MEM_WAIT drops the pending redirect
        idle(); mem_req = 1;
        step("rw_enter", 1, 0, 0, 2'd0, 2'd0, 0, 1);
        idle(); EX_redirect = 1;
        step("rw_redir", 1, 0, 0, 2'd0, 2'd0, 1, 1);
        idle(); rst = 1;
        step("rw_reset", 0, 0, 0, 2'd0, 2'd0, 0, 0);
        idle();
        step("rw_no_flush", 0, 0, 0, 2'd0, 2'd0, 0, 0);

        // Producer in MEM then WB, counter restarted from zero
        idle(); M_rd = 3; M_RegWrite = 1; ID_rs1 = 3;
        step("raw_mem", !F, 0, !F, F ? 2'd1 : 2'd0, 2'd0, 0, 0);
        idle(); W_rd = 3; W_RegWrite = 1; ID_rs1 = 3;
        step("raw_wb", !F, 0, !F, F ? 2'd2 : 2'd0, 2'd0, 0, 0);
        idle(); ID_rs1 = 3;
        step("raw_done", 0, 0, 0, 2'd0, 2'd0, 0, 0);
        idle(); EX_redirect = 1;
        step("redirect", 0, 1, 1, 2'd0, 2'd0, 0, 0);

        @(negedge clk); #1;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending entries, expected 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
